// File: rtl/pll_lock_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
// State encoding matches the debug value reported on state_o.
package pll_lock_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RST_PLL   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } pll_state_e;

    // Larger of two cycle parameters.
    function automatic int max_of(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Bits needed for a counter that reaches max_cyc-1.
    function automatic int cnt_width(input int max_cyc);
        if (max_cyc < 2) begin
            return 1;
        end else begin
            return $clog2(max_cyc);
        end
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for asynchronous status inputs.
// Synchronous reset clears both stages to 0.
module pll_lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock qualification sequencer.
// Drives the PLL reset, waits for a stable synchronized lock, then releases
// the datapath reset. Retries on lock timeout, re-sequences on loss of lock.
// Optional build macro PLL_LOCK_SEQ_LOL_FILTER_EN: require LOL_FILTER_CYC
// consecutive low lock cycles in RUN before declaring loss of lock.
module pll_lock_sequencer
    import pll_lock_seq_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int MAX_RETRY        = 7,
    parameter int LOL_FILTER_CYC   = 4
) (
    input  logic               CLKI,
    input  logic               RST,
    input  logic               en,
    input  logic               clr_fail,
    input  logic               pll_lock,
    output logic               pll_rst,
    output logic               dp_rst,
    output logic               ready,
    output logic               fail,
    output logic               lol_sticky,
    output logic [2:0]         retry_cnt,
    output logic [STATE_W-1:0] state_o
);

    localparam int MAX_CYC = max_of(max_of(RST_PULSE_CYC, LOCK_STABLE_CYC),
                                    max_of(LOCK_TIMEOUT_CYC, LOL_FILTER_CYC));
    localparam int CNT_W   = cnt_width(MAX_CYC);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [2:0]       MAX_RETRY_V = 3'(MAX_RETRY);
`ifdef PLL_LOCK_SEQ_LOL_FILTER_EN
    localparam logic [CNT_W-1:0] LOL_LAST   = CNT_W'(LOL_FILTER_CYC - 1);
`endif

    logic             lock_s;
    pll_state_e       state_r;
    pll_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       retry_r;
    logic [2:0]       retry_nxt_s;
    logic             lol_evt_s;
    logic             pll_rst_r;
    logic             dp_rst_r;
    logic             ready_r;
    logic             fail_r;
    logic             lol_r;
    logic             pll_rst_nxt_s;
    logic             dp_rst_nxt_s;
    logic             ready_nxt_s;
    logic             fail_nxt_s;
    logic             lol_nxt_s;

    pll_lock_sync #(.WIDTH(1)) u_lock_sync (
        .clk (CLKI),
        .rst (RST),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // State, counter, retry and output registers.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            retry_r   <= 3'd0;
            pll_rst_r <= 1'b1;
            dp_rst_r  <= 1'b1;
            ready_r   <= 1'b0;
            fail_r    <= 1'b0;
            lol_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            retry_r   <= retry_nxt_s;
            pll_rst_r <= pll_rst_nxt_s;
            dp_rst_r  <= dp_rst_nxt_s;
            ready_r   <= ready_nxt_s;
            fail_r    <= fail_nxt_s;
            lol_r     <= lol_nxt_s;
        end
    end

    // Next state, retry count and phase counter; en=0 overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        retry_nxt_s = retry_r;
        lol_evt_s   = 1'b0;
        if (!en) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_RST_PLL;
                    retry_nxt_s = 3'd0;
                end
                ST_RST_PLL: begin
                    if (cnt_r == RST_LAST) begin
                        state_nxt_s = ST_WAIT_LOCK;
                    end else begin
                        state_nxt_s = ST_RST_PLL;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (lock_s) begin
                        state_nxt_s = ST_STABLE;
                    end else if (cnt_r == TO_LAST) begin
                        if (retry_r >= MAX_RETRY_V) begin
                            state_nxt_s = ST_FAIL;
                        end else begin
                            retry_nxt_s = retry_r + 3'd1;
                            state_nxt_s = ST_RST_PLL;
                        end
                    end else begin
                        state_nxt_s = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_nxt_s = ST_WAIT_LOCK;
                    end else if (cnt_r == STB_LAST) begin
                        state_nxt_s = ST_RUN;
                        retry_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s = ST_STABLE;
                    end
                end
                ST_RUN: begin
`ifdef PLL_LOCK_SEQ_LOL_FILTER_EN
                    // cnt_r holds the length of the current lock dropout.
                    if (!lock_s && (cnt_r == LOL_LAST)) begin
`else
                    if (!lock_s) begin
`endif
                        lol_evt_s   = 1'b1;
                        state_nxt_s = ST_RST_PLL;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    if (clr_fail) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FAIL;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        // Counter restarts on every state entry.
        cnt_nxt_s = {CNT_W{1'b0}};
        if (state_nxt_s == state_r) begin
            case (state_r)
                ST_RST_PLL, ST_WAIT_LOCK, ST_STABLE: begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
`ifdef PLL_LOCK_SEQ_LOL_FILTER_EN
                ST_RUN: begin
                    if (lock_s) begin
                        cnt_nxt_s = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
`endif
                default: begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end
    end

    // Output values for the state being entered, plus sticky status bits.
    always_comb begin
        pll_rst_nxt_s = 1'b1;
        dp_rst_nxt_s  = 1'b1;
        ready_nxt_s   = 1'b0;
        case (state_nxt_s)
            ST_WAIT_LOCK, ST_STABLE: begin
                pll_rst_nxt_s = 1'b0;
            end
            ST_RUN: begin
                pll_rst_nxt_s = 1'b0;
                dp_rst_nxt_s  = 1'b0;
                ready_nxt_s   = 1'b1;
            end
            default: begin
                pll_rst_nxt_s = 1'b1;
            end
        endcase

        if (state_nxt_s == ST_FAIL) begin
            fail_nxt_s = 1'b1;
        end else if (en && clr_fail) begin
            fail_nxt_s = 1'b0;
        end else begin
            fail_nxt_s = fail_r;
        end

        if (lol_evt_s) begin
            lol_nxt_s = 1'b1;
        end else if (en && clr_fail) begin
            lol_nxt_s = 1'b0;
        end else begin
            lol_nxt_s = lol_r;
        end
    end

    assign pll_rst    = pll_rst_r;
    assign dp_rst     = dp_rst_r;
    assign ready      = ready_r;
    assign fail       = fail_r;
    assign lol_sticky = lol_r;
    assign retry_cnt  = retry_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_pll_lock_sequencer;

    localparam int P_RST  = 4;
    localparam int P_STB  = 8;
    localparam int P_TO   = 32;
    localparam int P_MAXR = 2;
`ifdef PLL_LOCK_SEQ_LOL_FILTER_EN
    localparam int LOL_N  = 4;
`else
    localparam int LOL_N  = 1;
`endif

    localparam int S_IDLE = 0, S_RST = 1, S_WAIT = 2, S_STB = 3, S_RUN = 4, S_FAIL = 5;

    logic       CLKI = 1'b0;
    logic       RST = 1'b1;
    logic       en = 1'b0;
    logic       clr_fail = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_rst, dp_rst, ready, fail, lol_sticky;
    logic [2:0] retry_cnt;
    logic [2:0] state_o;
    logic [10:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_state = 0, m_elapsed = 0, m_retry = 0, m_low_run = 0;
    bit m_fail = 0, m_lol = 0, m_s1 = 0, m_ls = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYC   (P_RST),
        .LOCK_STABLE_CYC (P_STB),
        .LOCK_TIMEOUT_CYC(P_TO),
        .MAX_RETRY       (P_MAXR),
        .LOL_FILTER_CYC  (4)
    ) dut (
        .CLKI      (CLKI),
        .RST       (RST),
        .en        (en),
        .clr_fail  (clr_fail),
        .pll_lock  (pll_lock),
        .pll_rst   (pll_rst),
        .dp_rst    (dp_rst),
        .ready     (ready),
        .fail      (fail),
        .lol_sticky(lol_sticky),
        .retry_cnt (retry_cnt),
        .state_o   (state_o)
    );

    always #5 CLKI = ~CLKI;

    assign dut_vec = {pll_rst, dp_rst, ready, fail, lol_sticky, retry_cnt, state_o};

    // Expected output vector from the model's current phase.
    function automatic logic [10:0] exp_vec();
        logic prst;
        prst = (m_state == S_IDLE) || (m_state == S_RST) || (m_state == S_FAIL);
        return {prst, (m_state != S_RUN), (m_state == S_RUN), m_fail, m_lol,
                3'(m_retry), 3'(m_state)};
    endfunction

    // One clock of the behavioural model, using the inputs seen at the edge.
    task automatic model_step();
        int nxt;
        int low_now;
        bit lol_evt;
        bit ls;
        if (RST) begin
            m_state = S_IDLE; m_elapsed = 0; m_retry = 0; m_fail = 0; m_lol = 0;
            m_s1 = 0; m_ls = 0; m_low_run = 0;
            return;
        end
        ls = m_ls;
        low_now = ls ? 0 : m_low_run + 1;
        nxt = m_state;
        lol_evt = 0;
        if (!en) begin
            nxt = S_IDLE;
        end else begin
            case (m_state)
                S_IDLE: begin nxt = S_RST; m_retry = 0; end
                S_RST:  if (m_elapsed + 1 == P_RST) nxt = S_WAIT;
                S_WAIT: begin
                    if (ls) nxt = S_STB;
                    else if (m_elapsed + 1 == P_TO) begin
                        if (m_retry == P_MAXR) nxt = S_FAIL;
                        else begin m_retry++; nxt = S_RST; end
                    end
                end
                S_STB: begin
                    if (!ls) nxt = S_WAIT;
                    else if (m_elapsed + 1 == P_STB) begin nxt = S_RUN; m_retry = 0; end
                end
                S_RUN:  if (low_now >= LOL_N) begin nxt = S_RST; lol_evt = 1; end
                S_FAIL: if (clr_fail) nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
        if (nxt == S_FAIL) m_fail = 1;
        else if (en && clr_fail) m_fail = 0;
        if (lol_evt) m_lol = 1;
        else if (en && clr_fail) m_lol = 0;
        m_elapsed = (nxt != m_state) ? 0 : m_elapsed + 1;
        m_state = nxt;
        m_low_run = low_now;
        m_ls = m_s1;
        m_s1 = pll_lock;
    endtask

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic tick();
        @(posedge CLKI);
        model_step();
        @(negedge CLKI);
    endtask

    task automatic test_reset();
        RST = 1'b1; en = 1'b0; clr_fail = 1'b0; pll_lock = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (dut_vec !== 11'b110_00_000_000) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected %b", dut_vec, 11'b110_00_000_000);
        end
        RST = 1'b0;
    endtask

    task automatic test_bring_up();
        int rst_cyc;
        int lat;
        rst_cyc = 0;
        en = 1'b1;
        for (int i = 0; i < 40 && !(state_o == 3'd2); i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL bringup_model: got %b expected %b", dut_vec, exp_vec());
            end
            if (state_o == 3'd1 && pll_rst == 1'b1) rst_cyc++;
        end
        n_checks++;
        if (rst_cyc !== P_RST) begin
            n_fail++; $display("FAIL bringup_rst_pulse: got %0d expected %0d", rst_cyc, P_RST);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL bringup_wait_model: got %b expected %b", dut_vec, exp_vec());
            end
        end
        pll_lock = 1'b1;
        lat = 0;
        for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
            tick();
            lat++;
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL bringup_lock_model: got %b expected %b", dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (lat !== 2 + P_STB + 1 || dp_rst !== 1'b0 || retry_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL bringup_ready_latency: got lat=%0d dp_rst=%b retry=%0d expected lat=%0d dp_rst=0 retry=0",
                     lat, dp_rst, retry_cnt, 2 + P_STB + 1);
        end
    endtask

    task automatic test_timeout_retry();
        int entries;
        logic [2:0] seen [3];
        logic [2:0] prev;
        RST = 1'b1; pll_lock = 1'b0; tick(); RST = 1'b0;
        en = 1'b1;
        entries = 0;
        prev = state_o;
        for (int i = 0; i < 300 && state_o !== 3'd5; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL retry_model: got %b expected %b", dut_vec, exp_vec());
            end
            if (state_o == 3'd1 && prev != 3'd1) begin
                if (entries < 3) seen[entries] = retry_cnt;
                entries++;
            end
            prev = state_o;
        end
        n_checks++;
        if (entries !== 3 || seen[0] !== 3'd0 || seen[1] !== 3'd1 || seen[2] !== 3'd2) begin
            n_fail++;
            $display("FAIL retry_sequence: got entries=%0d retries=%0d,%0d,%0d expected 3 entries 0,1,2",
                     entries, seen[0], seen[1], seen[2]);
        end
        n_checks++;
        if (fail !== 1'b1 || state_o !== 3'd5 || pll_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL fail_state: got fail=%b state=%0d pll_rst=%b expected 1,5,1", fail, state_o, pll_rst);
        end
        clr_fail = 1'b1; tick(); clr_fail = 1'b0;
        n_checks++;
        if (state_o !== 3'd0 || fail !== 1'b0) begin
            n_fail++; $display("FAIL clr_fail: got state=%0d fail=%b expected 0,0", state_o, fail);
        end
    endtask

    task automatic test_chatter();
        int stb_cyc;
        for (int i = 0; i < 60 && state_o !== 3'd2; i++) tick();
        pll_lock = 1'b1;
        for (int i = 0; i < 10 && state_o !== 3'd3; i++) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL chatter_model: got %b expected %b", dut_vec, exp_vec());
            end
        end
        pll_lock = 1'b0; tick(); pll_lock = 1'b1;
        for (int i = 0; i < 6 && state_o !== 3'd2; i++) tick();
        n_checks++;
        if (state_o !== 3'd2 || retry_cnt !== 3'd0) begin
            n_fail++; $display("FAIL chatter_back_to_wait: got state=%0d retry=%0d expected 2,0", state_o, retry_cnt);
        end
        stb_cyc = 0;
        for (int i = 0; i < 30 && state_o !== 3'd4; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL chatter_relock_model: got %b expected %b", dut_vec, exp_vec());
            end
            if (state_o == 3'd3) stb_cyc++;
        end
        n_checks++;
        if (stb_cyc !== P_STB || ready !== 1'b1) begin
            n_fail++; $display("FAIL chatter_window: got stable=%0d ready=%b expected %0d,1", stb_cyc, ready, P_STB);
        end
    endtask

    task automatic test_loss_of_lock();
        pll_lock = 1'b0; tick(); pll_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL lol_model: got %b expected %b", dut_vec, exp_vec());
            end
        end
`ifdef PLL_LOCK_SEQ_LOL_FILTER_EN
        n_checks++;
        if (state_o !== 3'd4 || lol_sticky !== 1'b0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL lol_glitch_ignored: got state=%0d lol=%b ready=%b expected 4,0,1",
                               state_o, lol_sticky, ready);
        end
        pll_lock = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        pll_lock = 1'b1;
        tick(); tick();
`endif
        n_checks++;
        if (lol_sticky !== 1'b1 || dp_rst !== 1'b1 || ready !== 1'b0 || state_o == 3'd4) begin
            n_fail++; $display("FAIL lol_detect: got lol=%b dp_rst=%b ready=%b state=%0d expected 1,1,0,!4",
                               lol_sticky, dp_rst, ready, state_o);
        end
        for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL lol_resequence_model: got %b expected %b", dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (ready !== 1'b1 || lol_sticky !== 1'b1) begin
            n_fail++; $display("FAIL lol_resequence: got ready=%b lol=%b expected 1,1", ready, lol_sticky);
        end
    endtask

    task automatic test_en_and_rst();
        pll_lock = 1'b0; tick(); tick(); tick(); pll_lock = 1'b1;
        for (int i = 0; i < 40 && state_o !== 3'd3; i++) tick();
        en = 1'b0; tick();
        n_checks++;
        if (state_o !== 3'd0 || pll_rst !== 1'b1 || dp_rst !== 1'b1 || lol_sticky !== m_lol) begin
            n_fail++; $display("FAIL en_drop: got state=%0d pll_rst=%b dp_rst=%b lol=%b expected 0,1,1,%b",
                               state_o, pll_rst, dp_rst, lol_sticky, m_lol);
        end
        en = 1'b1;
        for (int i = 0; i < 40 && state_o !== 3'd4; i++) tick();
        RST = 1'b1; tick(); RST = 1'b0;
        n_checks++;
        if (dut_vec !== 11'b110_00_000_000) begin
            n_fail++; $display("FAIL rst_in_run: got %b expected %b", dut_vec, 11'b110_00_000_000);
        end
    endtask

    task automatic test_random();
        int mode;
        mode = 0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 119) == 0) mode = $urandom_range(0, 2);
            if (mode == 0)      pll_lock = 1'b1;
            else if (mode == 1) pll_lock = 1'b0;
            else                pll_lock = ($urandom_range(0, 7) != 0);
            en       = ($urandom_range(0, 299) != 0);
            clr_fail = ($urandom_range(0, 29) == 0);
            RST      = ($urandom_range(0, 999) == 0);
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle_%0d: got %b expected %b", c, dut_vec, exp_vec());
            end
        end
        RST = 1'b0; clr_fail = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_timeout_retry();
        test_chatter();
        test_loss_of_lock();
        test_en_and_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the pixel-to-byte clock PLL: drives its reset, qualifies its LOCK output and releases the downstream datapath reset only after lock has been stable.
- Retries on lock timeout and re-sequences on loss of lock.
- Reports status to the control/register block.
- Sits between the board reference clock domain and the PLL wrapper instance; runs on the PLL input clock.

Parameters:
- RST_PULSE_CYC, 16: cycles pll_rst is held high per reset attempt (min 1).
- LOCK_STABLE_CYC, 1024: consecutive synchronized-lock cycles required before release.
- LOCK_TIMEOUT_CYC, 65536: cycles allowed in WAIT_LOCK before the attempt is declared failed.
- MAX_RETRY, 7: retries allowed after the first attempt before entering FAIL.
- LOL_FILTER_CYC, 4: loss-of-lock persistence, used only with the optional feature.

Ports:
- CLKI, in, 1: reference clock, same net as the PLL input clock.
- RST, in, 1: synchronous active-high reset.
- en, in, 1: level; 1 = bring up PLL, 0 = hold everything in reset.
- clr_fail, in, 1: single-cycle pulse; leaves FAIL.
- pll_lock, in, 1: raw PLL LOCK, asynchronous to CLKI.
- pll_rst, out, 1: PLL reset, active-high.
- dp_rst, out, 1: downstream pixel/byte datapath reset, active-high.
- ready, out, 1: PLL locked and datapath released.
- fail, out, 1: retries exhausted.
- lol_sticky, out, 1: a loss of lock occurred in RUN; cleared by RST or clr_fail.
- retry_cnt, out, 3: retries used in the current bring-up.
- state_o, out, 3: state encoding, for debug.

Behaviour:
- All outputs are registered.
- Reset values: pll_rst=1, dp_rst=1, ready=0, fail=0, lol_sticky=0, retry_cnt=0, state=IDLE.
- pll_lock passes through a 2-flop synchronizer to give lock_s, which lags by 2 cycles. Only lock_s is used.
- One internal counter of width clog2 of the largest cycle parameter. It is cleared on every state entry.
- Outputs per state:
  - IDLE: pll_rst=1, dp_rst=1, ready=0. en=1 moves to RST_PLL next cycle, with retry_cnt=0.
  - RST_PLL: pll_rst=1. After exactly RST_PULSE_CYC cycles in this state, moves to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0, dp_rst=1.
    - lock_s=1: move to STABLE.
    - Counter reaches LOCK_TIMEOUT_CYC-1 with lock_s=0 and retry_cnt==MAX_RETRY: move to FAIL.
    - Counter reaches LOCK_TIMEOUT_CYC-1 with lock_s=0 and retry_cnt<MAX_RETRY: increment retry_cnt and move to RST_PLL.
  - STABLE: pll_rst=0, dp_rst=1.
    - lock_s=0 on any cycle: return to WAIT_LOCK with a fresh timeout; retry_cnt is not incremented.
    - LOCK_STABLE_CYC consecutive lock_s=1 cycles: move to RUN.
  - RUN: dp_rst=0, ready=1, retry_cnt cleared on entry.
    - lock_s=0: set lol_sticky=1, and on the next cycle set dp_rst=1, ready=0 and move to RST_PLL.
  - FAIL: pll_rst=1, dp_rst=1, fail=1. clr_fail moves to IDLE and clears fail and lol_sticky.
- en=0 in any state: IDLE next cycle, overriding all else. Sticky and fail are preserved.
- Simultaneous events:
  - en=0 beats clr_fail.
  - A timeout on the same cycle lock_s rises goes to STABLE, because lock wins.
- RST mid-operation returns every output to its reset value on the next edge.
- retry_cnt saturates at MAX_RETRY and never wraps.
- dp_rst never deasserts unless the state is RUN.

Optional Feature:
- Macro: PLL_LOCK_SEQ_LOL_FILTER_EN.
- Defined: in RUN, lock_s must be 0 for LOL_FILTER_CYC consecutive cycles before loss of lock is declared. Shorter dropouts are ignored and do not set lol_sticky.
- Undefined: a single cycle of lock_s=0 in RUN triggers loss of lock. LOL_FILTER_CYC is unused.

Decomposition:
- Package pll_lock_seq_pkg:
  - State enumeration: IDLE=0, RST_PLL=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAIL=5.
  - Width of state_o.
  - Counter-width helper function.
- Sub-module pll_lock_sync: parameterized 2-flop synchronizer with synchronous reset to 0. It is reused for other asynchronous status inputs.

Test Plan:
Sim parameters for all scenarios: RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2.
1. Normal bring-up: en=1 at cycle 0, pll_lock rises 10 cycles after pll_rst falls.
   - pll_rst high for 4 cycles in RST_PLL.
   - ready=1 and dp_rst=0 exactly 2+8 cycles after lock rises plus the state-entry cycle.
   - retry_cnt=0.
2. Timeout and retry: pll_lock held 0.
   - Three RST_PLL pulses, with retry_cnt going 0 to 1 to 2.
   - Then fail=1, state_o=5, pll_rst=1.
   - clr_fail moves to IDLE with fail=0.
3. Lock chatter: lock drops for 1 cycle at stable count 5.
   - Returns to WAIT_LOCK, retry_cnt unchanged.
   - Relock gives ready after a full 8-cycle window.
4. Loss of lock in RUN: lock low for 1 cycle.
   - Without the feature: lol_sticky=1, dp_rst=1, re-sequence through RST_PLL.
   - With the feature and LOL_FILTER_CYC=4: no action. A 4-cycle low triggers it.
5. en=0 during STABLE, and RST asserted during RUN.
   - en=0: IDLE the next cycle.
   - RST: all outputs at reset values the next cycle, with lol_sticky=0.
